// File: rtl/lc3b_l1_cache.sv
// lc3b_l1_cache
// -----------------------------------------------------------------------------
// Two-way set-associative, write-back, write-allocate L1 cache between the
// LC-3b datapath memory port and physical memory.
//
// Geometry (fixed): 8 sets x 2 ways, 128-bit lines (8 x 16-bit words),
// 9-bit tags. Address split: tag [15:7], index [6:4], word [3:1]; bit 0 is
// the byte-within-word and only matters through mem_byte_enable.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_address       CPU byte address
//   mem_read          CPU read request, held until mem_resp
//   mem_write         CPU write request, held until mem_resp (wins over read)
//   mem_byte_enable   bit0 -> byte [7:0], bit1 -> byte [15:8]
//   mem_wdata         CPU write data
//   mem_rdata         selected word of the hit line (0 when nothing hits)
//   mem_resp          one-cycle completion strobe, combinational on a hit
//   pmem_address      line address to physical memory, bits [3:0] are 0
//   pmem_read         line fill request, held until pmem_resp
//   pmem_write        line writeback request, held until pmem_resp
//   pmem_wdata        victim line data for writeback
//   pmem_rdata        fill line data
//   pmem_resp         physical memory completion strobe
//
// Optional build macro: LC3B_L1_CACHE_PERF_EN
//   Adds hit_count[15:0] and miss_count[15:0] outputs. Functional behaviour
//   is identical with or without the macro.
//
// Handshake semantics: a CPU request is a level (mem_read/mem_write) that the
// CPU holds stable together with address, data and byte enables until the
// cycle in which mem_resp is high; that cycle is the single completion cycle
// and the CPU may change or drop the request after the following clock edge.
// Towards physical memory the cache holds pmem_read/pmem_write and the
// address/data stable until it samples pmem_resp high at a clock edge; the
// strobe drops in the next cycle. pmem_resp outside a transaction is ignored.
//
// FSM state is held in r_state (IDLE / WRITEBACK / FILL) for observation.
// -----------------------------------------------------------------------------
module lc3b_l1_cache (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef LC3B_L1_CACHE_PERF_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // Data and tags are not reset; valid bits gate every use of them.
  logic [127:0]    r_data [0:7][0:1];
  logic [8:0]      r_tag  [0:7][0:1];
  logic [7:0][1:0] r_valid;
  logic [7:0][1:0] r_dirty;
  logic [7:0]      r_lru;           // names the least-recently-used way

  state_t          r_state;
  logic            r_victim;        // way being written back / filled
  logic [15:0]     r_pmem_address;
  logic [127:0]    r_pmem_wdata;

  // ---------------------------------------------------------------------------
  // Address decode and parallel tag compare
  // ---------------------------------------------------------------------------
  logic [8:0]   w_tag;
  logic [2:0]   w_idx;
  logic [2:0]   w_off;
  logic         w_req;
  logic         w_is_write;
  logic         w_hit0;
  logic         w_hit1;
  logic         w_hit;
  logic         w_hit_way;
  logic [127:0] w_hit_line;
  logic [15:0]  w_hit_word;
  logic [127:0] w_merged_line;
  logic         w_do_hit;
  logic         w_do_miss;
  logic         w_victim;
  logic         w_victim_dirty;
  logic         w_fill_done;
  logic         w_unused_addr_bit0;

  assign w_tag      = mem_address[15:7];
  assign w_idx      = mem_address[6:4];
  assign w_off      = mem_address[3:1];
  assign w_req      = mem_read | mem_write;
  // A simultaneous read and write is handled as a write.
  assign w_is_write = mem_write;

  // Byte selection within the word is carried entirely by mem_byte_enable.
  assign w_unused_addr_bit0 = mem_address[0];

  assign w_hit0    = r_valid[w_idx][0] && (r_tag[w_idx][0] == w_tag);
  assign w_hit1    = r_valid[w_idx][1] && (r_tag[w_idx][1] == w_tag);
  assign w_hit     = w_hit0 | w_hit1;
  assign w_hit_way = w_hit1;

  assign w_hit_line = r_data[w_idx][w_hit_way];
  assign w_hit_word = w_hit_line[{w_off, 4'h0} +: 16];

  // Line image after merging the enabled bytes of a write hit.
  always_comb begin
    w_merged_line = w_hit_line;
    if (mem_byte_enable[0]) w_merged_line[{w_off, 4'h0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) w_merged_line[{w_off, 4'h8} +: 8] = mem_wdata[15:8];
  end

  assign w_do_hit  = (r_state == S_IDLE) && w_req && w_hit;
  assign w_do_miss = (r_state == S_IDLE) && w_req && !w_hit;

  // Lowest-numbered invalid way first; with both ways valid, evict the LRU way.
  assign w_victim       = !r_valid[w_idx][0] ? 1'b0 :
                          !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];
  assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];

  assign w_fill_done = (r_state == S_FILL) && pmem_resp;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // A completed fill returns to IDLE, where the still-held request hits and
  // finishes through this same path.
  assign mem_resp     = w_do_hit;
  assign mem_rdata    = w_hit ? w_hit_word : 16'h0000;

  // Strobes decode the registered state, so an asynchronous reset drops them
  // immediately.
  assign pmem_read    = (r_state == S_FILL);
  assign pmem_write   = (r_state == S_WRITEBACK);
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

  // ---------------------------------------------------------------------------
  // Data and tag arrays (no reset)
  // ---------------------------------------------------------------------------
  // The FILL state is left by reset, so an aborted fill never reaches here.
  always_ff @(posedge clk) begin
    if (w_do_hit && w_is_write) begin
      r_data[w_idx][w_hit_way] <= w_merged_line;
    end else if (w_fill_done) begin
      r_data[w_idx][r_victim] <= pmem_rdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM, valid/dirty/LRU state and pmem request registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_valid        <= '0;
      r_dirty        <= '0;
      r_lru          <= '0;
      r_victim       <= 1'b0;
      r_pmem_address <= 16'h0000;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_do_hit) begin
            r_lru[w_idx] <= ~w_hit_way;
            if (w_is_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
          end else if (w_do_miss) begin
            r_victim <= w_victim;
            if (w_victim_dirty) begin
              r_state        <= S_WRITEBACK;
              r_pmem_address <= {r_tag[w_idx][w_victim], w_idx, 4'h0};
              r_pmem_wdata   <= r_data[w_idx][w_victim];
            end else begin
              r_state        <= S_FILL;
              r_pmem_address <= {w_tag, w_idx, 4'h0};
            end
          end
        end

        S_WRITEBACK: begin
          if (pmem_resp) begin
            r_state        <= S_FILL;
            r_pmem_address <= {w_tag, w_idx, 4'h0};
          end
        end

        S_FILL: begin
          if (pmem_resp) begin
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= 1'b0;
            r_state                  <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LC3B_L1_CACHE_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  // r_missed marks a request that has already missed, so its final hit-path
  // completion after the fill is not counted as a hit.
  logic        r_missed;
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_missed     <= 1'b0;
      r_hit_count  <= 16'h0000;
      r_miss_count <= 16'h0000;
    end else begin
      if (w_do_hit) begin
        r_missed <= 1'b0;
        if (!r_missed) r_hit_count <= r_hit_count + 16'h0001;
      end else if (w_do_miss) begin
        r_missed     <= 1'b1;
        r_miss_count <= r_miss_count + 16'h0001;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_lc3b_l1_cache.sv
// tb_lc3b_l1_cache
// Scoreboard bench for lc3b_l1_cache. The reference model keeps a flat golden
// memory image plus, per set, the resident line addresses in recency order;
// hit/miss, victim choice, writeback contents and read data all follow from
// that. A responder process models physical memory with random latency.
module tb_lc3b_l1_cache;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
`ifdef LC3B_L1_CACHE_PERF_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  lc3b_l1_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
`ifdef LC3B_L1_CACHE_PERF_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [127:0] pm   [int];     // physical memory contents
  logic [127:0] gold [int];     // what the CPU should observe
  int           set_q [8][$];   // resident line addresses, front = LRU
  bit           dirty_m [int];  // line written since fill

  logic [16:0]  exp_q[$];       // {check_rdata, rdata}
  logic [144:0] exp_pm_q[$];    // {is_write, address, writeback data}

  int n_fill = 0;
  int n_wb   = 0;
  bit hold_resp = 1'b0;
  logic [15:0] last_rdata;

  function automatic logic [127:0] line_init(int la);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = 16'((la * 8 + w) * 40503) ^ 16'h5A5A;
    return l;
  endfunction

  function automatic logic [127:0] pm_get(int la);
    if (!pm.exists(la)) pm[la] = line_init(la);
    return pm[la];
  endfunction

  function automatic logic [127:0] gold_get(int la);
    if (!gold.exists(la)) gold[la] = line_init(la);
    return gold[la];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) set_q[i].delete();
    dirty_m.delete();
    gold.delete();
    foreach (pm[k]) gold[k] = pm[k];
  endtask

  task automatic predict(input logic [15:0] addr, input bit is_wr, output bit hit);
    int la;
    int idx;
    int pos;
    int v;
    la  = int'(addr[15:4]);
    idx = int'(addr[6:4]);
    pos = -1;
    for (int i = 0; i < set_q[idx].size(); i++) if (set_q[idx][i] == la) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      set_q[idx].delete(pos);
    end else begin
      hit = 1'b0;
      if (set_q[idx].size() == 2) begin
        v = set_q[idx].pop_front();
        if (dirty_m.exists(v) && dirty_m[v])
          exp_pm_q.push_back({1'b1, 16'(v << 4), gold_get(v)});
        dirty_m[v] = 1'b0;
      end
      exp_pm_q.push_back({1'b0, 16'(la << 4), 128'h0});
      dirty_m[la] = 1'b0;
    end
    set_q[idx].push_back(la);
    if (is_wr) dirty_m[la] = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // CPU driver
  // ---------------------------------------------------------------------------
  task automatic cpu_access(input logic [15:0] addr, input bit rd, input bit wr,
                            input logic [1:0] be, input logic [15:0] wd);
    bit           hit;
    int           cyc;
    int           la;
    logic [127:0] l;
    la = int'(addr[15:4]);
    predict(addr, wr, hit);
    l = gold_get(la);
    if (wr) begin
      exp_q.push_back({1'b0, 16'h0000});
      if (be[0]) l[{addr[3:1], 4'h0} +: 8] = wd[7:0];
      if (be[1]) l[{addr[3:1], 4'h8} +: 8] = wd[15:8];
      gold[la] = l;
    end else begin
      exp_q.push_back({1'b1, l[{addr[3:1], 4'h0} +: 16]});
    end
    @(posedge clk); #1;
    mem_address     = addr;
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    cyc = 0;
    @(negedge clk);
    while (!mem_resp && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    check("resp_within_budget", mem_resp, 1);
    if (hit) check("hit_latency", cyc, 0);
    else     check("miss_took_cycles", cyc > 0, 1);
    last_rdata = mem_rdata;
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: CPU responses
  // ---------------------------------------------------------------------------
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && mem_resp) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: got mem_resp=1 with no outstanding request");
        end else begin
          e = exp_q.pop_front();
          if (e[16]) check("rdata", mem_rdata, e[15:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Physical memory responder and pmem scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    int           cd;
    logic [144:0] e;
    cd = -1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!rst_n || !(pmem_read || pmem_write)) begin
        cd = -1;
      end else if (!hold_resp) begin
        if (cd < 0) cd = $urandom_range(0, 3);
        if (cd == 0) begin
          if (exp_pm_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pmem: got read=%0b write=%0b addr=%h with none expected",
                     pmem_read, pmem_write, pmem_address);
          end else begin
            e = exp_pm_q.pop_front();
            check("pmem_kind_is_write", pmem_write, e[144]);
            check("pmem_strobe_exclusive", pmem_read ^ pmem_write, 1);
            check("pmem_address", pmem_address, e[143:128]);
            if (e[144]) check("writeback_data", pmem_wdata, e[127:0]);
          end
          if (pmem_write) begin
            n_wb++;
            pm[int'(pmem_address[15:4])] = pmem_wdata;
          end else begin
            n_fill++;
            pmem_rdata = pm_get(int'(pmem_address[15:4]));
          end
          pmem_resp = 1'b1;
          cd = -1;
        end else begin
          cd--;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [127:0] l;
    logic [15:0]  orig_w1;
    int           fills_before;
    int           wbs_before;
    int           cyc;
    int           op;

    rst_n           = 1'b0;
    mem_address     = 16'h0000;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_wdata       = 16'h0000;

    // Line 0x0040 carries 0x1234 in word 3.
    l = line_init(4);
    l[63:48] = 16'h1234;
    pm[4]   = l;
    gold[4] = l;
    orig_w1 = l[31:16];

    repeat (3) @(negedge clk);
    check("rst_mem_resp",     mem_resp,     0);
    check("rst_pmem_read",    pmem_read,    0);
    check("rst_pmem_write",   pmem_write,   0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata",   pmem_wdata,   0);
    check("rst_mem_rdata",    mem_rdata,    0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Cold read, then a hit in the same line.
    cpu_access(16'h0046, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("cold_read_rdata", last_rdata, 16'h1234);
    check("cold_read_fills", n_fill, 1);
    check("cold_read_wbs",   n_wb,   0);
    cpu_access(16'h004E, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("hit_read_no_fill", n_fill, 1);
`ifdef LC3B_L1_CACHE_PERF_EN
    check("perf_hit_count",  hit_count,  1);
    check("perf_miss_count", miss_count, 1);
`endif

    // Upper-byte write, low byte preserved.
    cpu_access(16'h0043, 1'b0, 1'b1, 2'b10, 16'hAB00);
    cpu_access(16'h0042, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("byte_merge_word1", last_rdata, {8'hAB, orig_w1[7:0]});

    // Three lines in set 4: the dirty LRU line 0x0040 is written back.
    wbs_before = n_wb;
    cpu_access(16'h0040, 1'b1, 1'b0, 2'b00, 16'h0000);
    cpu_access(16'h00C0, 1'b1, 1'b0, 2'b00, 16'h0000);
    cpu_access(16'h0140, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("evict_dirty_wb", n_wb - wbs_before, 1);

    // Reset in the middle of a fill.
    hold_resp = 1'b1;
    @(posedge clk); #1;
    mem_address = 16'h0200;
    mem_read    = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!pmem_read && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check("abort_fill_started", pmem_read, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_pmem_read_drop",  pmem_read,  0);
    check("abort_pmem_write_low",  pmem_write, 0);
    check("abort_mem_resp_low",    mem_resp,   0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    hold_resp = 1'b0;
    model_reset();

    fills_before = n_fill;
    cpu_access(16'h0040, 1'b1, 1'b0, 2'b00, 16'h0000);
    check("post_reset_refill", n_fill - fills_before, 1);

    // Randomized traffic over four tags per set to force evictions.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a  = {9'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      op = $urandom_range(0, 9);
      if (op < 5)      cpu_access(a, 1'b1, 1'b0, 2'b00, 16'h0000);
      else if (op < 9) cpu_access(a, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
      else             cpu_access(a, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
    end

    repeat (5) @(posedge clk);
    check("exp_q_drained",    exp_q.size(),    0);
    check("exp_pm_q_drained", exp_pm_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
